// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and controller state shared by the ALU and the control unit
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_MULU = 4'b1011;
  localparam logic [3:0] ALU_DIVU = 4'b1100;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative unsigned shift-add multiply / restoring divide, one bit per clock
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt;
  logic div_r, ge;
  logic [WIDTH-1:0] hr, lr, dr;
  logic [WIDTH:0] s, t;
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  // lo/hi are the register values after the current iteration, so the final step is visible as done rises
  always_comb begin
    s = {1'b0, hr} + (lr[0] ? {1'b0, dr} : '0);
    t = {hr, lr[WIDTH-1]};
    ge = t >= {1'b0, dr};
    lo = div_r ? {lr[WIDTH-2:0], ge} : {s[0], lr[WIDTH-1:1]};
    hi = div_r ? (ge ? WIDTH'(t - {1'b0, dr}) : t[WIDTH-1:0]) : s[WIDTH:1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      div_r <= 1'b0;
      hr <= '0;
      lr <= '0;
      dr <= '0;
    end else if (go) begin
      cnt <= CW'(WIDTH);
      div_r <= is_div;
      hr <= '0;
      lr <= a;
      dr <= b;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      hr <= hi;
      lr <= lo;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with start/done handshake and iterative MULU/DIVU
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluctr,
  input  logic [WIDTH-1:0] busa,
  input  logic [WIDTH-1:0] busb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);
  state_t state, nstate;
  logic is_md, go, fin, md_busy, md_done, ovf;
  logic [SHW-1:0] sh;
  logic [WIDTH-1:0] sum, dif, res, md_lo, md_hi;
  logic [WIDTH:0] slt, sltu;
  alu_muldiv_seq #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .rst(rst), .go(go), .is_div(aluctr == ALU_DIVU),
    .a(busa), .b(busb), .busy(md_busy), .done(md_done), .lo(md_lo), .hi(md_hi)
  );
  assign busy = (state == RUN) && md_busy;
  always_comb begin
    sh = busb[SHW-1:0];
    sum = busa + busb;
    dif = busa - busb;
    slt = {busa[WIDTH-1], busa} - {busb[WIDTH-1], busb};
    sltu = {1'b0, busa} - {1'b0, busb};
    res = '0;
    ovf = 1'b0;
    case (aluctr)
      ALU_ADD: begin
        res = sum;
        ovf = (busa[WIDTH-1] == busb[WIDTH-1]) && (sum[WIDTH-1] != busa[WIDTH-1]);
      end
      ALU_SUB: begin
        res = dif;
        ovf = (busa[WIDTH-1] != busb[WIDTH-1]) && (dif[WIDTH-1] != busa[WIDTH-1]);
      end
      ALU_AND:  res = busa & busb;
      ALU_OR:   res = busa | busb;
      ALU_XOR:  res = busa ^ busb;
      ALU_NOR:  res = ~(busa | busb);
      ALU_SLT:  res = WIDTH'(slt[WIDTH]);
      ALU_SLTU: res = WIDTH'(sltu[WIDTH]);
      ALU_SLL:  res = busa << sh;
      ALU_SRL:  res = busa >> sh;
      ALU_SRA:  res = $signed(busa) >>> sh;
      default:  res = '0;
    endcase
  end
  always_comb begin
    is_md = (aluctr == ALU_MULU) || (aluctr == ALU_DIVU);
    go = (state == IDLE) && start && is_md;
    fin = (state == RUN) && md_done;
    nstate = go ? RUN : fin ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nstate;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      result <= '0;
      result_hi <= '0;
      zero <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start && !is_md) begin
        done <= 1'b1;
        result <= res;
        result_hi <= '0;
        zero <= res == '0;
        overflow <= ovf;
      end else if (fin) begin
        done <= 1'b1;
        result <= md_lo;
        result_hi <= md_hi;
        zero <= md_lo == '0;
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vector table plus hand-written multi-cycle sequences for alu_mc
module tb_alu_mc;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] aluctr = '0;
  logic [W-1:0] busa = '0, busb = '0;
  logic busy, done, zero, overflow;
  logic [W-1:0] result, result_hi;
  int checks = 0, failures = 0;
  int n, dn;
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, v;
  } vec_t;
  vec_t vt[15];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .aluctr(aluctr), .busa(busa), .busb(busb),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    aluctr = op;
    busa = a;
    busb = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] eh,
                        input int inj);
    int cyc, nb;
    issue(op, a, b);
    cyc = 0;
    nb = 0;
    while (!done && cyc < 60) begin
      if (busy) nb++;
      if (cyc == inj) begin
        aluctr = ALU_ADD;
        busa = 2;
        busb = 3;
        start = 1'b1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({name, "_latency"}, 64'(cyc), 64'd32);
    chk({name, "_busycycles"}, 64'(nb), 64'd32);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({name, "_lo"}, 64'(result), 64'(er));
    chk({name, "_hi"}, 64'(result_hi), 64'(eh));
    chk({name, "_zero"}, 64'(zero), 64'(er == '0));
    chk({name, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    vt[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vt[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vt[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vt[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vt[4]  = '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0};
    vt[5]  = '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0};
    vt[6]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vt[7]  = '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
    vt[8]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
    vt[9]  = '{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[10] = '{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0};
    vt[11] = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[12] = '{4'b1101,  32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};
    vt[13] = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vt[14] = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_result", i), 64'(result), 64'(vt[i].r));
      chk($sformatf("v%0d_hi", i), 64'(result_hi), 64'd0);
      chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vt[i].z));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vt[i].v));
      @(posedge clk);
      #1 chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
    end

    run_md("mul_ff_2", ALU_MULU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, -1);
    run_md("mul_ff_ff", ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, -1);
    run_md("div_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, -1);
    run_md("div_by0", ALU_DIVU, 32'h00001234, 32'h0, 32'hFFFFFFFF, 32'h00001234, -1);

    run_md("div_ign", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 4);
    @(posedge clk);
    #1 chk("ign_no_extra_done", 64'(done), 64'd0);
    chk("ign_result_held", 64'(result), 64'd14);

    issue(ALU_MULU, 32'h00000003, 32'h00000005);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_hi", 64'(result_hi), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    issue(ALU_ADD, 32'd2, 32'd3);
    chk("postrst_add_done", 64'(done), 64'd1);
    chk("postrst_add_result", 64'(result), 64'd5);

    run_md("b2b_mul", ALU_MULU, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, -1);
    aluctr = ALU_ADD;
    busa = 32'd2;
    busb = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_result", 64'(result), 64'd5);
    chk("b2b_hi", 64'(result_hi), 64'd0);

    @(negedge clk);
    aluctr = ALU_MULU;
    busa = 32'd7;
    busb = 32'd7;
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_vs_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (busy || done) n++;
    end
    chk("rst_vs_start_idle", 64'(n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
